// File: rtl/neuron_cfg_loader_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_cfg_loader_pkg
//  Description : Shared constants for the neuron configuration byte loader:
//                opcodes, broadcast ID, transaction types, FSM encodings.
//  Revision    : 1.0 - initial release
// ============================================================================
package neuron_cfg_loader_pkg;

    // Packet opcodes (first byte of every packet)
    localparam logic [7:0] OP_SET_CTRL        = 8'h01;
    localparam logic [7:0] OP_WEIGHT_SET      = 8'h02;
    localparam logic [7:0] OP_ADDR_WEIGHT_SET = 8'h03;
    localparam logic [7:0] OP_END             = 8'hFF;

    // ID byte value that addresses every neuron at once
    localparam logic [7:0] BCAST_ID = 8'hFF;

    // cfg_type encodings
    localparam logic [1:0] CFG_CTRL   = 2'd1;
    localparam logic [1:0] CFG_WEIGHT = 2'd2;

    // Loader FSM encodings
    localparam int                 STATE_W  = 3;
    localparam logic [STATE_W-1:0] ST_OPC   = 3'd0;
    localparam logic [STATE_W-1:0] ST_ID    = 3'd1;
    localparam logic [STATE_W-1:0] ST_CTRL  = 3'd2;
    localparam logic [STATE_W-1:0] ST_ADDR  = 3'd3;
    localparam logic [STATE_W-1:0] ST_VALUE = 3'd4;
    localparam logic [STATE_W-1:0] ST_EMIT  = 3'd5;

    // True for opcodes that start a multi-byte configuration packet
    function automatic logic is_cfg_opcode(input logic [7:0] b);
        return (b == OP_SET_CTRL) || (b == OP_WEIGHT_SET) || (b == OP_ADDR_WEIGHT_SET);
    endfunction

endpackage
`default_nettype wire

// File: rtl/neuron_cfg_loader_byte_assembler.sv
`default_nettype none
// ============================================================================
//  Module      : cfg_byte_assembler
//  Description : Collects a little-endian multi-byte word from a byte stream.
//                The caller selects how many bytes make up the word via the
//                index of the last byte; o_word already contains the byte
//                presented in the current cycle so it can be captured on the
//                same edge that consumes the final byte.
//  Revision    : 1.0 - initial release
// ============================================================================
module cfg_byte_assembler #(
    parameter int WORD_W = 32,
    parameter int CNT_W  = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              i_clear,
    input  logic              i_shift_en,
    input  logic [7:0]        i_byte,
    input  logic [CNT_W-1:0]  i_last_idx,
    output logic              o_last,
    output logic [WORD_W-1:0] o_word
);

    localparam int NBYTES = WORD_W / 8;

    logic [CNT_W-1:0]  r_cnt;
    logic [WORD_W-1:0] r_word;
    logic [WORD_W-1:0] w_word;

    assign o_last = i_shift_en && (r_cnt == i_last_idx);
    assign o_word = w_word;

    // Merge the incoming byte into the lane selected by the byte counter
    generate
        for (genvar i = 0; i < NBYTES; i++) begin : g_lane
            assign w_word[i*8 +: 8] = (i_shift_en && (r_cnt == CNT_W'(i))) ? i_byte
                                                                            : r_word[i*8 +: 8];
        end
    endgenerate

    // Byte counter and word storage; counter rewinds after the last byte
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt  <= '0;
            r_word <= '0;
        end else if (i_clear) begin
            r_cnt  <= '0;
        end else if (i_shift_en) begin
            r_word <= w_word;
            r_cnt  <= o_last ? '0 : r_cnt + CNT_W'(1);
        end
    end

endmodule
`default_nettype wire

// File: rtl/neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : neuron_cfg_loader
//  Description : Byte-stream configuration decoder for the neuron array.
//                Parses opcode/ID/payload packets from a valid/ready byte
//                interface and emits one registered config transaction per
//                packet, addressed to one neuron or broadcast to all.
//  Revision    : 1.0 - initial release
// ============================================================================
module neuron_cfg_loader
    import neuron_cfg_loader_pkg::*;
#(
    parameter int NUM_NEURONS = 32,
    parameter int ADDR_W      = 10,
    parameter int VALUE_W     = 32,
    parameter int ID_W        = $clog2(NUM_NEURONS)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    input  logic [7:0]         in_data,
    output logic               in_ready,
    output logic               cfg_valid,
    input  logic               cfg_ready,
    output logic [1:0]         cfg_type,
    output logic [ID_W-1:0]    cfg_id,
    output logic               cfg_bcast,
    output logic [ADDR_W-1:0]  cfg_addr,
    output logic [VALUE_W-1:0] cfg_value,
    output logic [2:0]         decay_mode,
    output logic [2:0]         init_mode_adder,
    output logic [1:0]         adder_model,
    output logic               init_mode_acc,
    output logic               neuron_mode,
    output logic               run_start,
    output logic               err
);

    // The assembler is shared between the 2-byte fields and the value, so it
    // must be at least 16 bits wide even for narrow values.
    localparam int VALUE_BYTES = VALUE_W / 8;
    localparam int ASM_W       = (VALUE_W > 16) ? VALUE_W : 16;
    localparam int ASM_BYTES   = ASM_W / 8;
    localparam int ASM_CNT_W   = $clog2(ASM_BYTES);

    logic [STATE_W-1:0] r_state;
    logic [7:0]         r_opc;
    logic               r_discard;
    logic [ADDR_W-1:0]  r_ptr;

    logic               r_cfg_valid;
    logic [1:0]         r_cfg_type;
    logic [ID_W-1:0]    r_cfg_id;
    logic               r_cfg_bcast;
    logic [ADDR_W-1:0]  r_cfg_addr;
    logic [VALUE_W-1:0] r_cfg_value;
    logic [2:0]         r_decay_mode;
    logic [2:0]         r_init_mode_adder;
    logic [1:0]         r_adder_model;
    logic               r_init_mode_acc;
    logic               r_neuron_mode;
    logic               r_run_start;
    logic               r_err;

    logic                 w_fire;
    logic                 w_asm_shift;
    logic                 w_asm_clear;
    logic                 w_asm_last;
    logic [ASM_CNT_W-1:0] w_asm_last_idx;
    logic [ASM_W-1:0]     w_asm_word;

    assign in_ready = (r_state != ST_EMIT);
    assign w_fire   = in_valid && in_ready;

    assign w_asm_shift    = w_fire && ((r_state == ST_CTRL) || (r_state == ST_ADDR) ||
                                       (r_state == ST_VALUE));
    assign w_asm_clear    = w_fire && (r_state == ST_ID);
    assign w_asm_last_idx = (r_state == ST_VALUE) ? ASM_CNT_W'(VALUE_BYTES - 1)
                                                  : ASM_CNT_W'(1);

    cfg_byte_assembler #(
        .WORD_W (ASM_W),
        .CNT_W  (ASM_CNT_W)
    ) u_asm (
        .clk        (clk),
        .rst        (rst),
        .i_clear    (w_asm_clear),
        .i_shift_en (w_asm_shift),
        .i_byte     (in_data),
        .i_last_idx (w_asm_last_idx),
        .o_last     (w_asm_last),
        .o_word     (w_asm_word)
    );

    // Packet-parsing FSM with all outputs registered
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state           <= ST_OPC;
            r_opc             <= 8'h00;
            r_discard         <= 1'b0;
            r_ptr             <= '0;
            r_cfg_valid       <= 1'b0;
            r_cfg_type        <= 2'd0;
            r_cfg_id          <= '0;
            r_cfg_bcast       <= 1'b0;
            r_cfg_addr        <= '0;
            r_cfg_value       <= '0;
            r_decay_mode      <= 3'd0;
            r_init_mode_adder <= 3'd0;
            r_adder_model     <= 2'd0;
            r_init_mode_acc   <= 1'b0;
            r_neuron_mode     <= 1'b1;
            r_run_start       <= 1'b0;
            r_err             <= 1'b0;
        end else begin
            r_run_start <= 1'b0;
            r_err       <= 1'b0;
            case (r_state)
                ST_OPC: begin
                    if (w_fire) begin
                        if (in_data == OP_END) begin
                            r_run_start   <= 1'b1;
                            r_neuron_mode <= 1'b0;
                        end else if (is_cfg_opcode(in_data)) begin
                            r_neuron_mode <= 1'b1;
                            r_opc         <= in_data;
                            r_discard     <= 1'b0;
                            r_state       <= ST_ID;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                ST_ID: begin
                    if (w_fire) begin
                        if (in_data == BCAST_ID) begin
                            r_cfg_bcast <= 1'b1;
                            r_cfg_id    <= '0;
                        end else if (32'(in_data) < NUM_NEURONS) begin
                            r_cfg_bcast <= 1'b0;
                            r_cfg_id    <= in_data[ID_W-1:0];
                        end else begin
                            // Out-of-range target: payload is still consumed
                            // so the stream stays framed, then dropped.
                            r_discard <= 1'b1;
                        end
                        if (r_opc == OP_SET_CTRL)
                            r_state <= ST_CTRL;
                        else if (r_opc == OP_WEIGHT_SET)
                            r_state <= ST_VALUE;
                        else if (r_opc == OP_ADDR_WEIGHT_SET)
                            r_state <= ST_ADDR;
                        else
                            r_state <= ST_OPC;
                    end
                end
                ST_CTRL: begin
                    if (w_asm_last) begin
                        if (!r_discard) begin
                            r_decay_mode      <= w_asm_word[2:0];
                            r_init_mode_adder <= w_asm_word[5:3];
                            r_adder_model     <= w_asm_word[7:6];
                            r_init_mode_acc   <= w_asm_word[8];
                            r_cfg_type        <= CFG_CTRL;
                            r_cfg_valid       <= 1'b1;
                        end
                        r_state <= ST_EMIT;
                    end
                end
                ST_ADDR: begin
                    if (w_asm_last) begin
                        // A dropped packet must leave the pointer untouched
                        if (!r_discard)
                            r_ptr <= w_asm_word[ADDR_W-1:0];
                        r_state <= ST_VALUE;
                    end
                end
                ST_VALUE: begin
                    if (w_asm_last) begin
                        if (!r_discard) begin
                            r_cfg_value <= w_asm_word[VALUE_W-1:0];
                            r_cfg_addr  <= r_ptr;
                            r_cfg_type  <= CFG_WEIGHT;
                            r_cfg_valid <= 1'b1;
                        end
                        r_state <= ST_EMIT;
                    end
                end
                ST_EMIT: begin
                    if (r_discard) begin
                        r_err   <= 1'b1;
                        r_state <= ST_OPC;
                    end else if (r_cfg_valid && cfg_ready) begin
                        r_cfg_valid <= 1'b0;
                        r_state     <= ST_OPC;
                        if (r_cfg_type == CFG_WEIGHT)
                            r_ptr <= r_ptr + ADDR_W'(1);
                    end
                end
                default: begin
                    r_state <= ST_OPC;
                end
            endcase
        end
    end

    assign cfg_valid       = r_cfg_valid;
    assign cfg_type        = r_cfg_type;
    assign cfg_id          = r_cfg_id;
    assign cfg_bcast       = r_cfg_bcast;
    assign cfg_addr        = r_cfg_addr;
    assign cfg_value       = r_cfg_value;
    assign decay_mode      = r_decay_mode;
    assign init_mode_adder = r_init_mode_adder;
    assign adder_model     = r_adder_model;
    assign init_mode_acc   = r_init_mode_acc;
    assign neuron_mode     = r_neuron_mode;
    assign run_start       = r_run_start;
    assign err             = r_err;

endmodule
`default_nettype wire

// File: tb/tb_neuron_cfg_loader.sv
`default_nettype none
// ============================================================================
//  Module      : tb_neuron_cfg_loader
//  Description : Self-checking bench for neuron_cfg_loader. Directed packets
//                followed by random packets, compared against a packet-level
//                reference model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_neuron_cfg_loader;

    localparam int NN = 32;
    localparam int AW = 10;
    localparam int VW = 32;
    localparam int IW = 5;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          in_valid = 1'b0;
    logic [7:0]    in_data = 8'h00;
    logic          in_ready;
    logic          cfg_valid;
    logic          cfg_ready = 1'b0;
    logic [1:0]    cfg_type;
    logic [IW-1:0] cfg_id;
    logic          cfg_bcast;
    logic [AW-1:0] cfg_addr;
    logic [VW-1:0] cfg_value;
    logic [2:0]    decay_mode;
    logic [2:0]    init_mode_adder;
    logic [1:0]    adder_model;
    logic          init_mode_acc;
    logic          neuron_mode;
    logic          run_start;
    logic          err;

    always #5 clk = ~clk;

    neuron_cfg_loader #(
        .NUM_NEURONS (NN),
        .ADDR_W      (AW),
        .VALUE_W     (VW)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .in_valid        (in_valid),
        .in_data         (in_data),
        .in_ready        (in_ready),
        .cfg_valid       (cfg_valid),
        .cfg_ready       (cfg_ready),
        .cfg_type        (cfg_type),
        .cfg_id          (cfg_id),
        .cfg_bcast       (cfg_bcast),
        .cfg_addr        (cfg_addr),
        .cfg_value       (cfg_value),
        .decay_mode      (decay_mode),
        .init_mode_adder (init_mode_adder),
        .adder_model     (adder_model),
        .init_mode_acc   (init_mode_acc),
        .neuron_mode     (neuron_mode),
        .run_start       (run_start),
        .err             (err)
    );

    typedef struct packed {
        logic [1:0]    typ;
        logic [IW-1:0] id;
        logic          bc;
        logic [AW-1:0] addr;
        logic [VW-1:0] val;
        logic [2:0]    dm;
        logic [2:0]    ima;
        logic [1:0]    am;
        logic          acc;
    } txn_t;

    int   total = 0;
    int   bad   = 0;
    int   n_err = 0;
    int   n_run = 0;
    int   exp_err = 0;
    int   exp_run = 0;
    logic bp_hold = 1'b0;
    txn_t got_q[$];
    logic [7:0] pkt_q[$];

    // Reference model state (packet-level view of the loader)
    logic [AW-1:0] m_ptr  = '0;
    logic [2:0]    m_dm   = '0;
    logic [2:0]    m_ima  = '0;
    logic [1:0]    m_am   = '0;
    logic          m_acc  = 1'b0;
    logic          m_mode = 1'b1;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        total++;
        if (obs !== expv) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, expv);
        end
    endtask

    txn_t w_snap;
    assign w_snap = {cfg_type, cfg_id, cfg_bcast, cfg_addr, cfg_value,
                     decay_mode, init_mode_adder, adder_model, init_mode_acc};

    // Random consumer readiness, changed just after each active edge
    initial begin
        forever begin
            @(posedge clk);
            #1;
            cfg_ready = bp_hold ? 1'b0 : ($urandom_range(0, 3) != 0);
        end
    end

    // Output monitor: collects transfers, counts pulses, checks hold stability
    logic p_hold = 1'b0;
    txn_t p_snap = '0;
    always @(negedge clk) begin
        if (rst) begin
            p_hold <= 1'b0;
        end else begin
            if (cfg_valid)
                check("in_ready_while_valid", in_ready, 1'b0);
            if (p_hold) begin
                check("hold_valid", cfg_valid, 1'b1);
                check("hold_fields", w_snap, p_snap);
            end
            if (cfg_valid && cfg_ready)
                got_q.push_back(w_snap);
            if (err)
                n_err <= n_err + 1;
            if (run_start)
                n_run <= n_run + 1;
            p_hold <= cfg_valid && !cfg_ready;
            p_snap <= w_snap;
        end
    end

    task automatic send_byte(input logic [7:0] b);
        int waits;
        waits = 0;
        repeat ($urandom_range(0, 2)) @(negedge clk);
        @(negedge clk);
        in_valid = 1'b1;
        in_data  = b;
        while (!in_ready && waits < 100) begin
            @(negedge clk);
            waits++;
        end
        if (!in_ready)
            check("in_ready_timeout", in_ready, 1'b1);
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    // Sends pkt_q as one packet, predicts its effect, and compares
    task automatic run_pkt(input int hold);
        txn_t          e;
        txn_t          g;
        logic          has_txn;
        logic          disc;
        logic [7:0]    opc;
        logic [7:0]    id;
        logic [15:0]   a;
        int            vb;
        int            t;
        e       = '0;
        has_txn = 1'b0;
        disc    = 1'b0;
        opc     = pkt_q[0];
        if (opc == 8'hFF) begin
            exp_run++;
            m_mode = 1'b0;
        end else if (opc < 8'd1 || opc > 8'd3) begin
            exp_err++;
        end else begin
            m_mode = 1'b1;
            id     = pkt_q[1];
            disc   = (id != 8'hFF) && (int'(id) >= NN);
            e.bc   = (id == 8'hFF);
            e.id   = e.bc ? '0 : id[IW-1:0];
            if (opc == 8'd1) begin
                e.typ = 2'd1;
                if (!disc) begin
                    m_dm  = pkt_q[2][2:0];
                    m_ima = pkt_q[2][5:3];
                    m_am  = pkt_q[2][7:6];
                    m_acc = pkt_q[3][0];
                end
            end else begin
                e.typ = 2'd2;
                vb    = 2;
                if (opc == 8'd3) begin
                    a  = {pkt_q[3], pkt_q[2]};
                    vb = 4;
                    if (!disc)
                        m_ptr = a[AW-1:0];
                end
                e.val  = {pkt_q[vb+3], pkt_q[vb+2], pkt_q[vb+1], pkt_q[vb]};
                e.addr = m_ptr;
                if (!disc)
                    m_ptr = m_ptr + 1'b1;
            end
            e.dm  = m_dm;
            e.ima = m_ima;
            e.am  = m_am;
            e.acc = m_acc;
            if (disc)
                exp_err++;
            else
                has_txn = 1'b1;
        end

        for (int i = 0; i < pkt_q.size(); i++)
            send_byte(pkt_q[i]);
        check("valid_latency", cfg_valid, has_txn);

        if (hold > 0) begin
            repeat (hold) begin
                @(negedge clk);
                check("bp_valid", cfg_valid, 1'b1);
                check("bp_in_ready", in_ready, 1'b0);
            end
            bp_hold = 1'b0;
        end

        t = 0;
        while ((got_q.size() != int'(has_txn) || n_err != exp_err || n_run != exp_run) && t < 200) begin
            @(negedge clk);
            t++;
        end
        repeat (3) @(negedge clk);
        check("txn_count", got_q.size(), has_txn);
        check("err_count", n_err, exp_err);
        check("run_count", n_run, exp_run);
        check("neuron_mode", neuron_mode, m_mode);
        if (has_txn && got_q.size() > 0) begin
            g = got_q.pop_front();
            check("cfg_type", g.typ, e.typ);
            check("cfg_bcast", g.bc, e.bc);
            check("cfg_id", g.id, e.id);
            if (e.typ == 2'd2) begin
                check("cfg_addr", g.addr, e.addr);
                check("cfg_value", g.val, e.val);
            end
            check("ctrl_fields", {g.dm, g.ima, g.am, g.acc}, {e.dm, e.ima, e.am, e.acc});
        end
        got_q.delete();
    endtask

    task automatic gen_random();
        int         k;
        int         r;
        logic [7:0] id;
        logic [7:0] b;
        k = $urandom_range(0, 9);
        r = $urandom_range(0, 9);
        if (r < 7)       id = 8'($urandom_range(0, NN - 1));
        else if (r == 7) id = 8'hFF;
        else             id = 8'($urandom_range(NN, 254));
        pkt_q.delete();
        if (k <= 2) begin
            pkt_q = {8'h01, id, 8'($urandom), 8'($urandom)};
        end else if (k <= 5) begin
            pkt_q = {8'h02, id, 8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        end else if (k <= 7) begin
            pkt_q = {8'h03, id, 8'($urandom), 8'($urandom),
                     8'($urandom), 8'($urandom), 8'($urandom), 8'($urandom)};
        end else if (k == 8) begin
            pkt_q = {8'hFF};
        end else begin
            b = 8'($urandom);
            while (b == 8'h01 || b == 8'h02 || b == 8'h03 || b == 8'hFF)
                b = 8'($urandom);
            pkt_q = {b};
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        rst = 1'b1;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_in_ready", in_ready, 1'b1);
        check("rst_neuron_mode", neuron_mode, 1'b1);
        check("rst_cfg_valid", cfg_valid, 1'b0);
        check("rst_err_run", {err, run_start}, 2'b00);
        check("rst_cfg_fields", w_snap, '0);
        rst = 1'b0;

        // Directed packets
        pkt_q = {8'h01, 8'h03, 8'hD5, 8'h01};
        run_pkt(0);
        check("ctrl_decay_mode", decay_mode, 3'd5);
        check("ctrl_adder_model", adder_model, 2'd3);
        pkt_q = {8'h03, 8'h07, 8'hFF, 8'h03, 8'h78, 8'h56, 8'h34, 8'h12};
        run_pkt(0);
        pkt_q = {8'h02, 8'h07, 8'h01, 8'h00, 8'h00, 8'h00};
        run_pkt(0);
        check("wrap_addr", cfg_addr, 10'h000);

        bp_hold = 1'b1;
        @(posedge clk);
        #2;
        pkt_q = {8'h02, 8'h11, 8'hEF, 8'hBE, 8'hAD, 8'hDE};
        run_pkt(5);

        pkt_q = {8'h01, 8'hFF, 8'h2A, 8'h00};
        run_pkt(0);
        pkt_q = {8'h02, 8'h40, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(0);
        pkt_q = {8'h03, 8'h40, 8'h55, 8'h01, 8'h11, 8'h22, 8'h33, 8'h44};
        run_pkt(0);
        pkt_q = {8'h02, 8'h01, 8'h99, 8'h00, 8'h00, 8'h00};
        run_pkt(0);
        pkt_q = {8'h55};
        run_pkt(0);
        pkt_q = {8'hFF};
        run_pkt(0);
        pkt_q = {8'h01, 8'h05, 8'h00, 8'h01};
        run_pkt(0);

        // Random packets
        for (int n = 0; n < 150; n++) begin
            gen_random();
            run_pkt(0);
        end

        // Reset in the middle of an ADDR_WEIGHT_SET packet
        pkt_q = {8'h03, 8'h07, 8'hFF};
        for (int i = 0; i < pkt_q.size(); i++)
            send_byte(pkt_q[i]);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        #1;
        check("midrst_cfg_valid", cfg_valid, 1'b0);
        check("midrst_in_ready", in_ready, 1'b1);
        check("midrst_neuron_mode", neuron_mode, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        m_ptr  = '0;
        m_dm   = '0;
        m_ima  = '0;
        m_am   = '0;
        m_acc  = 1'b0;
        m_mode = 1'b1;
        pkt_q = {8'h02, 8'h00, 8'hAA, 8'hBB, 8'hCC, 8'hDD};
        run_pkt(0);
        check("midrst_addr", cfg_addr, 10'h000);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
